// File: rtl/io_uart_tx.sv
// io_uart_tx: buffers 64-bit LOG words in a small FIFO and sends each one
// over an 8N1 UART line, byte 0 (io_data[7:0]) first. No back-pressure:
// words arriving while the FIFO is full are dropped and flagged in overflow.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line high; pops the FIFO head into the shift register
// START | start bit (low) for CLKS_PER_BIT clocks
// DATA  | eight data bits of the current byte, LSB first
// STOP  | stop bit (high); then next byte of the word, or back to IDLE
module io_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          io_write,
    input  logic [63:0]                   io_data,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_bit_idx;
    logic [2:0]      r_byte_idx;
    logic [63:0]     r_shift;
    logic            r_tx;
    logic            r_busy;
    logic            r_overflow;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [63:0]     r_mem [FIFO_DEPTH];

    state_t          w_state_nxt;
    logic [TW-1:0]   w_timer_nxt;
    logic [2:0]      w_bit_idx_nxt;
    logic [2:0]      w_byte_idx_nxt;
    logic [63:0]     w_shift_nxt;
    logic            w_tx_nxt;
    logic            w_timer_done;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic [CW-1:0]   w_count_nxt;
    logic [7:0]      w_cur_byte;
    logic [2:0]      w_bit_inc;

    // A full FIFO still accepts a word when the head leaves at the same edge.
    assign w_timer_done = (r_timer == TW'(CLKS_PER_BIT - 1));
    assign w_full       = (r_count == CW'(FIFO_DEPTH));
    assign w_pop        = (r_state == S_IDLE) && (r_count != '0);
    assign w_push       = io_write && (!w_full || w_pop);
    assign w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
    assign w_cur_byte   = r_shift[7:0];
    assign w_bit_inc    = r_bit_idx + 3'd1;

    // Next-state and next-output decode for the frame sequencer.
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = '0;
        w_bit_idx_nxt  = r_bit_idx;
        w_byte_idx_nxt = r_byte_idx;
        w_shift_nxt    = r_shift;
        w_tx_nxt       = r_tx;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_pop) begin
                    w_shift_nxt    = r_mem[r_rd_ptr];
                    w_byte_idx_nxt = 3'd0;
                    w_state_nxt    = S_START;
                    w_tx_nxt       = 1'b0;
                end
            end
            S_START: begin
                w_timer_nxt = w_timer_done ? '0 : r_timer + TW'(1);
                if (w_timer_done) begin
                    w_state_nxt   = S_DATA;
                    w_bit_idx_nxt = 3'd0;
                    w_tx_nxt      = w_cur_byte[0];
                end
            end
            S_DATA: begin
                w_timer_nxt = w_timer_done ? '0 : r_timer + TW'(1);
                if (w_timer_done) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_idx_nxt = w_bit_inc;
                        w_tx_nxt      = w_cur_byte[w_bit_inc];
                    end
                end
            end
            S_STOP: begin
                w_timer_nxt = w_timer_done ? '0 : r_timer + TW'(1);
                if (w_timer_done) begin
                    if (r_byte_idx != 3'd7) begin
                        w_byte_idx_nxt = r_byte_idx + 3'd1;
                        w_shift_nxt    = {8'h00, r_shift[63:8]};
                        w_state_nxt    = S_START;
                        w_tx_nxt       = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    // Sequencer state, line driver and status flags; reset abandons any frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
            if (io_write && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers gate every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= io_data;
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign overflow   = r_overflow;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx: a line receiver decodes every frame
// and compares it with bytes queued from the words written.
module tb_io_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int NV    = 4;

    logic        clk;
    logic        rst_n;
    logic        io_write;
    logic [63:0] io_data;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [2:0]  fifo_count;

    io_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .io_write   (io_write),
        .io_data    (io_data),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  exp_b [8];
    } vec_t;

    vec_t       vecs [NV];
    logic [7:0] exp_q [$];
    int         start_q [$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line receiver: each bit must hold its level for exactly CPB samples.
    logic       mon_active = 1'b0;
    logic       mon_bad    = 1'b0;
    logic [7:0] mon_byte   = 8'h00;
    int         mon_pos    = 0;
    int         mon_k;
    int         mon_ph;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_pos    = 1;
                mon_bad    = 1'b0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_k  = mon_pos / CPB;
            mon_ph = mon_pos % CPB;
            if (mon_k == 0) begin
                if (tx !== 1'b0) mon_bad = 1'b1;
            end else if (mon_k <= 8) begin
                if (mon_ph == 0) mon_byte[mon_k-1] = tx;
                else if (tx !== mon_byte[mon_k-1]) mon_bad = 1'b1;
            end else begin
                if (tx !== 1'b1) mon_bad = 1'b1;
            end
            mon_pos++;
            if (mon_pos == 10*CPB) begin
                if (exp_q.size() == 0) check("unexpected_frame", 64'(mon_byte), 64'hx0);
                else check("rx_byte", 64'(mon_byte), 64'(exp_q.pop_front()));
                check("frame_shape", 64'(mon_bad), 64'd0);
                mon_active = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [63:0] d);
        @(negedge clk);
        io_write = 1'b1;
        io_data  = d;
        @(posedge clk);
        #1;
        io_write = 1'b0;
        io_data  = $urandom();
    endtask

    task automatic push_bytes(input logic [63:0] d);
        for (int b = 0; b < 8; b++) exp_q.push_back(d[8*b +: 8]);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", 64'(busy), 64'd0);
        repeat (2) tick();
    endtask

    // Words queued back-to-back: bytes 10*CPB apart, words one idle clock apart.
    task automatic check_gaps(input int nwords);
        check("frame_count", 64'(start_q.size()), 64'(8*nwords));
        for (int i = 1; i < start_q.size(); i++)
            check("frame_gap", 64'(start_q[i] - start_q[i-1]),
                  64'((i % 8 == 0) ? 10*CPB + 1 : 10*CPB));
        check("exp_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        start_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          c0;
        int          len;
        int          peak;
        logic [63:0] words [6];

        vecs[0].data  = 64'h0000_0000_0000_0041;
        vecs[0].exp_b = '{8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1].data  = 64'h0807_0605_0403_0201;
        vecs[1].exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        vecs[2].data  = 64'h0000_0000_0000_1234;
        vecs[2].exp_b = '{8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3].data  = 64'hFF00_8001_7E3C_C3AA;
        vecs[3].exp_b = '{8'hAA, 8'hC3, 8'h3C, 8'h7E, 8'h01, 8'h80, 8'h00, 8'hFF};

        rst_n    = 1'b0;
        io_write = 1'b0;
        io_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Table: single words, latency and frame length.
        for (int v = 0; v < NV; v++) begin
            start_q.delete();
            for (int b = 0; b < 8; b++) exp_q.push_back(vecs[v].exp_b[b]);
            write_word(vecs[v].data);
            check("e0_count", 64'(fifo_count), 64'd1);
            check("e0_tx", 64'(tx), 64'd1);
            check("e0_busy", 64'(busy), 64'd1);
            tick();
            check("e1_tx", 64'(tx), 64'd0);
            check("e1_count", 64'(fifo_count), 64'd0);
            n = 0;
            while (busy === 1'b1 && n < 100*CPB) begin
                tick();
                n++;
            end
            check("word_clocks", 64'(n), 64'(80*CPB));
            check("word_overflow", 64'(overflow), 64'd0);
            repeat (2) tick();
            check_gaps(1);
        end

        // Random bursts that never overflow: up to DEPTH+1 consecutive writes.
        for (int r = 0; r < 3; r++) begin
            start_q.delete();
            len  = $urandom_range(1, DEPTH + 1);
            peak = 0;
            for (int i = 0; i < len; i++) begin
                words[i] = {$urandom(), $urandom()};
                push_bytes(words[i]);
                write_word(words[i]);
                if (int'(fifo_count) > peak) peak = int'(fifo_count);
            end
            check("rand_peak", 64'(peak), 64'((len <= 2) ? 1 : len - 1));
            wait_idle(len*80*CPB + 50);
            check("rand_overflow", 64'(overflow), 64'd0);
            check_gaps(len);
        end

        // Burst of DEPTH+2: the last word is dropped and overflow sticks.
        start_q.delete();
        peak = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            words[i] = {$urandom(), $urandom()};
            if (i < DEPTH + 1) push_bytes(words[i]);
            write_word(words[i]);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        check("burst_peak", 64'(peak), 64'(DEPTH));
        check("burst_overflow", 64'(overflow), 64'd1);
        wait_idle((DEPTH+1)*80*CPB + 50);
        check("burst_overflow_sticky", 64'(overflow), 64'd1);
        check_gaps(DEPTH + 1);

        // Full FIFO written at the exact edge IDLE pops the second word.
        do_reset();
        repeat (2) tick();
        for (int i = 0; i < DEPTH + 1; i++) begin
            words[i] = {$urandom(), $urandom()};
            push_bytes(words[i]);
            write_word(words[i]);
            if (i == 0) c0 = cyc;
        end
        while (cyc < c0 + 80*CPB + 1) tick();
        check("full_before_pop", 64'(fifo_count), 64'(DEPTH));
        words[5] = {$urandom(), $urandom()};
        push_bytes(words[5]);
        write_word(words[5]);
        check("full_pop_cycle", 64'(cyc), 64'(c0 + 80*CPB + 2));
        check("full_pop_count", 64'(fifo_count), 64'(DEPTH));
        check("full_pop_overflow", 64'(overflow), 64'd0);
        wait_idle((DEPTH+1)*80*CPB + 50);
        check("full_overflow_end", 64'(overflow), 64'd0);
        check_gaps(DEPTH + 2);

        // Reset mid-frame: byte 2, data bit 3 (a zero bit), FIFO full, overflow set.
        start_q.delete();
        for (int i = 0; i < DEPTH + 2; i++) begin
            words[i] = (i == 0) ? 64'hFFFF_FFFF_FF00_FFFF : {$urandom(), $urandom()};
            if (i < DEPTH + 1) push_bytes(words[i]);
            write_word(words[i]);
            if (i == 0) c0 = cyc;
        end
        while (cyc < c0 + 2 + 24*CPB) tick();
        check("pre_rst_tx", 64'(tx), 64'd0);
        check("pre_rst_overflow", 64'(overflow), 64'd1);
        check("pre_rst_count", 64'(fifo_count), 64'(DEPTH));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", 64'(tx), 64'd1);
        check("async_rst_count", 64'(fifo_count), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_overflow", 64'(overflow), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        start_q.delete();
        repeat (2) tick();
        push_bytes(64'h0000_0000_0000_0041);
        write_word(64'h0000_0000_0000_0041);
        tick();
        check("post_rst_start", 64'(tx), 64'd0);
        wait_idle(100*CPB);
        check("post_rst_overflow", 64'(overflow), 64'd0);
        check_gaps(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
